// File: rtl/priority_encoder1_4to2.sv
// 4-to-2 priority encoder with registered outputs.
// The most significant set bit of d wins; q carries its index and v flags
// that at least one request bit was set. Both outputs appear one clock
// after d is sampled. q is forced to 0 whenever v is 0, so there is never
// a stale index on the bus.
module priority_encoder1_4to2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [1:0] q,
  output logic       v
);

  logic [1:0] next_code;
  logic       next_valid;

  // Pick the index of the highest set request bit; an empty vector encodes as 0.
  always_comb begin
    next_code  = 2'd0;
    next_valid = |d;
    casez (d)
      4'b1???: next_code = 2'd3;
      4'b01??: next_code = 2'd2;
      4'b001?: next_code = 2'd1;
      4'b0001: next_code = 2'd0;
      default: next_code = 2'd0;
    endcase
  end

  // Register the encoded result every cycle; a synchronous reset overrides the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 2'd0;
      v <= 1'b0;
    end else begin
      q <= next_code;
      v <= next_valid;
    end
  end

endmodule

// File: tb/tb_priority_encoder1_4to2.sv
// Self-checking bench for priority_encoder1_4to2: a directed vector table,
// an exhaustive sweep, randomized traffic against a reference model, and
// hand-written sequences for reset timing and output stability.
module tb_priority_encoder1_4to2;

  logic       clk;
  logic       reset;
  logic [3:0] d;
  logic [1:0] q;
  logic       v;

  int compared;
  int mismatched;

  typedef struct {
    logic       rst;
    logic [3:0] d;
    logic [1:0] q;
    logic       v;
  } vec_t;

  vec_t vecs[16];

  priority_encoder1_4to2 dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q),
    .v     (v)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the index of the most significant set bit is floor(log2(d)),
  // i.e. clog2(d+1)-1 for nonzero d; an empty request vector gives code 0.
  function automatic logic [2:0] model(input logic [3:0] dv);
    int val;
    int idx;
    val = int'(dv);
    if (val == 0) return 3'b000;
    idx = $clog2(val + 1) - 1;
    return {idx[1:0], 1'b1};
  endfunction

  // Drive one cycle's inputs, let the edge happen, then settle past it.
  task automatic apply_stimulus(input logic r, input logic [3:0] dv);
    reset = r;
    d     = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [1:0] exp_q, input logic exp_v);
    compared++;
    if (q !== exp_q || v !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got q=%0d v=%0b, expected q=%0d v=%0b", name, q, v, exp_q, exp_v);
    end
  endtask

  initial begin
    logic [2:0]  ref_out;
    logic [3:0]  rd;
    logic        rr;
    logic [1:0]  held_q;
    logic        held_v;

    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    d          = 4'b0000;

    // Directed table: each row is one clock edge and the q/v expected after it.
    vecs[0]  = '{1'b1, 4'b1111, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[4]  = '{1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[6]  = '{1'b0, 4'b1111, 2'd3, 1'b1};
    vecs[7]  = '{1'b0, 4'b1001, 2'd3, 1'b1};
    vecs[8]  = '{1'b0, 4'b0101, 2'd2, 1'b1};
    vecs[9]  = '{1'b0, 4'b0110, 2'd2, 1'b1};
    vecs[10] = '{1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 4'b0011, 2'd1, 1'b1};
    vecs[12] = '{1'b1, 4'b1000, 2'd0, 1'b0};
    vecs[13] = '{1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[14] = '{1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[15] = '{1'b1, 4'b0000, 2'd0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].d);
      check_output($sformatf("table[%0d] d=%b rst=%b", i, vecs[i].d, vecs[i].rst), vecs[i].q, vecs[i].v);
    end

    // Exhaustive sweep, one value per cycle, back to back.
    for (int i = 0; i < 16; i++) begin
      rd = 4'(i);
      ref_out = model(rd);
      apply_stimulus(1'b0, rd);
      check_output($sformatf("sweep d=%b", rd), ref_out[2:1], ref_out[0]);
    end

    // Reset pulse entirely between edges must not disturb the registers.
    apply_stimulus(1'b0, 4'b0100);
    check_output("pre-glitch d=0100", 2'd2, 1'b1);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_output("mid-cycle reset pulse", 2'd2, 1'b1);

    // Changing d between edges must not reach q/v before the next edge.
    held_q = 2'd2;
    held_v = 1'b1;
    d = 4'b1000;
    #2;
    check_output("hold after d change", held_q, held_v);
    @(posedge clk);
    #1;
    check_output("load after d change", 2'd3, 1'b1);

    // Reset raised between edges takes effect only at the next edge.
    d = 4'b0010;
    #1;
    reset = 1'b1;
    #1;
    check_output("reset before edge", 2'd3, 1'b1);
    @(posedge clk);
    #1;
    check_output("reset at edge", 2'd0, 1'b0);
    apply_stimulus(1'b0, 4'b0010);
    check_output("first edge after reset", 2'd1, 1'b1);

    // Randomized traffic with occasional resets against the reference model.
    for (int i = 0; i < 300; i++) begin
      rd = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 15) == 0);
      ref_out = rr ? 3'b000 : model(rd);
      apply_stimulus(rr, rd);
      check_output($sformatf("random[%0d] d=%b rst=%b", i, rd, rr), ref_out[2:1], ref_out[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
